// File: rtl/ntt_pkg.sv
// Shared constants and FSM encoding for the NTT address scheduler.
// Sized for the 256-point ML-DSA forward transform.
package ntt_pkg;

  localparam int N        = 256;
  localparam int LOG_N    = 8;
  localparam int PIPE_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// Cooley-Tukey butterfly address generator.
// Maps (stage s, butterfly b) to pair addresses and zeta index.
module ntt_addr_gen #(
  parameter  int ADDR_W = 8,
  localparam int SW     = $clog2(ADDR_W),
  localparam int BW     = ADDR_W - 1
) (
  input  logic [SW-1:0]     s,
  input  logic [BW-1:0]     b,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] zeta_addr
);

  logic [SW-1:0]     sh;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] lm;
  logic [ADDR_W-1:0] bx;
  logic [ADDR_W-1:0] g;
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] hi;
  logic [ADDR_W-1:0] j;

  // 2*len*g == 2*(b with its low log2(len) bits cleared)
  always_comb begin
    sh        = SW'(ADDR_W - 1) - s;
    len       = {1'b1, {BW{1'b0}}} >> s;
    lm        = len - ADDR_W'(1);
    bx        = {1'b0, b};
    g         = bx >> sh;
    off       = bx & lm;
    hi        = bx & ~lm;
    j         = (hi << 1) | off;
    rd_addr0  = j;
    rd_addr1  = j + len;
    zeta_addr = (ADDR_W'(1) << s) + g;
  end

endmodule

// File: rtl/ntt_scheduler.sv
// Forward NTT scheduler: walks stages/butterflies, drains the
// read-to-write pipe between stages and delays writes to match.
module ntt_scheduler
  import ntt_pkg::*;
#(
  parameter int ADDR_W   = LOG_N,
  parameter int PIPE_LAT = ntt_pkg::PIPE_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] zeta_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [ADDR_W-1:0] wr_addr1
);

  localparam int SW = $clog2(ADDR_W);
  localparam int BW = ADDR_W - 1;
  localparam int CW = $clog2(PIPE_LAT + 1);

  state_t            state;
  logic [SW-1:0]     s;
  logic [BW-1:0]     b;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] a0;
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] za;
  logic              run;
  logic              last_s;
  logic              drained;

  logic [PIPE_LAT-1:0] en_q;
  logic [ADDR_W-1:0]   w0_q [PIPE_LAT];
  logic [ADDR_W-1:0]   w1_q [PIPE_LAT];

  ntt_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr (
    .s        (s),
    .b        (b),
    .rd_addr0 (a0),
    .rd_addr1 (a1),
    .zeta_addr(za)
  );

  assign run     = (state == RUN);
  assign last_s  = (s == SW'(ADDR_W - 1));
  assign drained = (cnt == CW'(PIPE_LAT - 1));

  assign busy      = run | (state == DRAIN);
  assign done      = (state == DONE);
  assign rd_en     = run;
  assign rd_addr0  = run ? a0 : '0;
  assign rd_addr1  = run ? a1 : '0;
  assign zeta_addr = run ? za : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      s     <= '0;
      b     <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            s     <= '0;
            b     <= '0;
          end
        end
        RUN: begin
          b <= b + BW'(1);
          if (&b) begin
            state <= DRAIN;
            cnt   <= '0;
          end
        end
        DRAIN: begin
          cnt <= cnt + CW'(1);
          if (drained) begin
            if (last_s) begin
              state <= DONE;
            end else begin
              state <= RUN;
              s     <= s + SW'(1);
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Idle reads carry zero addresses, so idle writes do too.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        w0_q[i] <= '0;
        w1_q[i] <= '0;
      end
    end else begin
      en_q[0] <= rd_en;
      w0_q[0] <= rd_addr0;
      w1_q[0] <= rd_addr1;
      for (int i = 1; i < PIPE_LAT; i++) begin
        en_q[i] <= en_q[i-1];
        w0_q[i] <= w0_q[i-1];
        w1_q[i] <= w1_q[i-1];
      end
    end
  end

  assign wr_en    = en_q[PIPE_LAT-1];
  assign wr_addr0 = w0_q[PIPE_LAT-1];
  assign wr_addr1 = w1_q[PIPE_LAT-1];

endmodule

// File: tb/tb_ntt_scheduler.sv
// Scoreboard bench for ntt_scheduler with an attached RAM,
// zeta ROM and registered mod-q butterfly model.
module tb_ntt_scheduler;

  localparam int Q = 8380417;

  typedef struct packed {
    logic [15:0] cyc;
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic [7:0]  z;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [7:0] rd_addr0;
  logic [7:0] rd_addr1;
  logic [7:0] zeta_addr;
  logic       wr_en;
  logic [7:0] wr_addr0;
  logic [7:0] wr_addr1;

  ev_t rdq[$];
  ev_t wrq[$];
  int  doneq[$];

  int compared = 0;
  int mism     = 0;
  int edgecnt  = 0;
  int ec       = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  int busy_cnt = 0;

  int   mem [256];
  int   r0, r1, zz, o0, o1;
  logic v1;

  logic       pv0, pv1;
  logic [7:0] p0a, p0b, p1a, p1b;

  ntt_scheduler dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .zeta_addr(zeta_addr),
    .wr_en    (wr_en),
    .wr_addr0 (wr_addr0),
    .wr_addr1 (wr_addr1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edgecnt <= edgecnt + 1;

  function automatic int cur_rel();
    return edgecnt - ec + 1;
  endfunction

  function automatic int zeta(input logic [7:0] a);
    return (int'(a) * 4093 + 17) % Q;
  endfunction

  function automatic int bf_add(input int x, input int z, input int y);
    longint t;
    t = (longint'(z) * longint'(y)) % Q;
    return int'((longint'(x) + t) % Q);
  endfunction

  function automatic int bf_sub(input int x, input int z, input int y);
    longint t;
    t = (longint'(z) * longint'(y)) % Q;
    return int'((longint'(x) - t + Q) % Q);
  endfunction

  function automatic logic hit(input logic [7:0] x, input logic [7:0] y0,
                               input logic [7:0] y1);
    return (x == y0) || (x == y1);
  endfunction

  task automatic check(input string nm, input logic [39:0] got,
                       input logic [39:0] exp);
    compared++;
    if (got !== exp) begin
      mism++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // external RAM -> ROM -> registered butterfly -> RAM
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0;
    end else begin
      v1 <= rd_en;
      if (rd_en) begin
        r0 <= mem[rd_addr0];
        r1 <= mem[rd_addr1];
        zz <= zeta(zeta_addr);
      end
      if (v1) begin
        o0 <= bf_add(r0, zz, r1);
        o1 <= bf_sub(r0, zz, r1);
      end
      if (wr_en) begin
        mem[wr_addr0] <= o0;
        mem[wr_addr1] <= o1;
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents an event
  always @(negedge clk) begin
    int  rel;
    ev_t got;
    ev_t exp;
    logic hz;
    rel = cur_rel();
    if (!reset) begin
      pv0 = 1'b0;
      pv1 = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (rd_en) begin
        rd_cnt++;
        got = {16'(rel), rd_addr0, rd_addr1, zeta_addr};
        if (rdq.size() == 0) begin
          check("rd_stray", got, 40'd0);
        end else begin
          exp = rdq.pop_front();
          check("rd_event", got, exp);
        end
        hz = (pv0 && (hit(rd_addr0, p0a, p0b) || hit(rd_addr1, p0a, p0b)))
          || (pv1 && (hit(rd_addr0, p1a, p1b) || hit(rd_addr1, p1a, p1b)));
        check("hazard", 40'(hz), 40'd0);
      end else begin
        check("rd_idle_addr", 40'({rd_addr0, rd_addr1, zeta_addr}), 40'd0);
      end
      if (wr_en) begin
        wr_cnt++;
        got = {16'(rel), wr_addr0, wr_addr1, 8'd0};
        if (wrq.size() == 0) begin
          check("wr_stray", got, 40'd0);
        end else begin
          exp = wrq.pop_front();
          check("wr_event", got, exp);
        end
      end else begin
        check("wr_idle_addr", 40'({wr_addr0, wr_addr1}), 40'd0);
      end
      if (done) begin
        if (doneq.size() == 0) check("done_stray", 40'(rel), 40'd0);
        else check("done_cycle", 40'(rel), 40'(doneq.pop_front()));
      end
      pv1 = pv0;
      p1a = p0a;
      p1b = p0b;
      pv0 = rd_en;
      p0a = rd_addr0;
      p0b = rd_addr1;
    end
  end

  task automatic launch(input int n);
    int len, g, off, j;
    rdq.delete();
    wrq.delete();
    doneq.delete();
    rd_cnt   = 0;
    wr_cnt   = 0;
    busy_cnt = 0;
    for (int s = 0; s < 8; s++) begin
      for (int b = 0; b < 128; b++) begin
        len = 128 >> s;
        g   = b >> (7 - s);
        off = b & (len - 1);
        j   = 2 * len * g + off;
        rdq.push_back({16'(1 + 130*s + b), 8'(j), 8'(j + len),
                       8'((1 << s) + g)});
        wrq.push_back({16'(3 + 130*s + b), 8'(j), 8'(j + len), 8'd0});
      end
    end
    doneq.push_back(1041);
    start = 1'b1;
    @(posedge clk);
    #1 ec = edgecnt;
    repeat (n) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_rel(input int k);
    int guard = 0;
    while (cur_rel() < k && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic wait_done();
    int guard = 0;
    while (!done && guard < 1200) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", 40'(done), 40'd1);
    check("done_rel", 40'(cur_rel()), 40'd1041);
    check("busy_cycles", 40'(busy_cnt), 40'd1040);
    check("rd_count", 40'(rd_cnt), 40'd1024);
    check("wr_count", 40'(wr_cnt), 40'd1024);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = (i == 0) ? 1 : 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ctl", 40'({busy, done, rd_en, wr_en}), 40'd0);
    check("rst_addr", 40'({rd_addr0, rd_addr1, zeta_addr,
                           wr_addr0, wr_addr1}), 40'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // delta transform, start held for three cycles
    launch(3);
    check("c3_wr", 40'({wr_en, wr_addr0, wr_addr1}), 40'({1'b1, 8'd0, 8'd128}));
    wait_rel(195);
    check("c195_rd", 40'({rd_en, rd_addr0, rd_addr1, zeta_addr}),
          40'({1'b1, 8'd128, 8'd192, 8'd3}));
    wait_rel(1038);
    check("c1038_rd", 40'({rd_en, rd_addr0, rd_addr1, zeta_addr}),
          40'({1'b1, 8'd254, 8'd255, 8'd255}));
    wait_done();
    for (int i = 0; i < 256; i++) check($sformatf("delta_mem%0d", i),
                                        40'(mem[i]), 40'd1);
    repeat (5) @(negedge clk);
    check("idle_after", 40'({busy, done, rd_en, wr_en}), 40'd0);

    // abort mid-transform
    launch(1);
    check("c1_rd", 40'({rd_en, rd_addr0, rd_addr1, zeta_addr}),
          40'({1'b1, 8'd0, 8'd128, 8'd1}));
    wait_rel(500);
    check("c500_busy", 40'(busy), 40'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_ctl", 40'({busy, done, rd_en, wr_en}), 40'd0);
    check("abort_addr", 40'({rd_addr0, rd_addr1, zeta_addr,
                             wr_addr0, wr_addr1}), 40'd0);
    rdq.delete();
    wrq.delete();
    doneq.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // clean restart after abort
    launch(1);
    check("re_c1_rd", 40'({rd_en, rd_addr0, rd_addr1, zeta_addr}),
          40'({1'b1, 8'd0, 8'd128, 8'd1}));
    wait_rel(3);
    check("re_c3_wr", 40'({wr_en, wr_addr0, wr_addr1}),
          40'({1'b1, 8'd0, 8'd128}));
    wait_done();
    repeat (5) @(negedge clk);
    check("queues_empty", 40'(rdq.size() + wrq.size() + doneq.size()), 40'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule

// File: doc/ntt_scheduler.md
NTT_SCHEDULER -- requirements
Module: ntt_scheduler

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the coefficient/zeta address width (N = 256).
REQ-002 The block SHALL have parameter PIPE_LAT, default 2, meaning the read-to-write latency (1 RAM/ROM read cycle plus 1 registered butterfly cycle).
REQ-003 The block SHALL have port clk, input, 1 bit: the clock.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request one forward 256-point NTT.
REQ-006 The block SHALL have port busy, output, 1 bit: a transform is in progress.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-008 The block SHALL have port rd_en, input-side, output, 1 bit: coefficient RAM read strobe.
REQ-009 The block SHALL have ports rd_addr0 and rd_addr1, outputs, ADDR_W bits each: addresses of a[j] (to butterfly in0) and a[j+len] (to butterfly in1).
REQ-010 The block SHALL have port zeta_addr, output, ADDR_W bits: zeta ROM address; the ROM output drives butterfly phi.
REQ-011 The block SHALL have port wr_en, output, 1 bit: RAM write strobe for butterfly out0/out1.
REQ-012 The block SHALL have ports wr_addr0 and wr_addr1, outputs, ADDR_W bits each: write addresses for out0 and out1.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-014 In IDLE, start=1 SHALL be accepted; the FSM SHALL enter RUN with stage s=0 and butterfly index b=0.
REQ-015 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-016 In RUN, rd_en SHALL be 1 every cycle and b SHALL increment 0..127.
REQ-017 Addressing SHALL use len = 128>>s, g = b>>(7-s), off = b&(len-1), j = 2*len*g + off.
REQ-018 rd_addr0 SHALL be j, rd_addr1 SHALL be j+len, and zeta_addr SHALL be (1<<s)+g, giving the range 1..255 over the transform.
REQ-019 After b=127 the FSM SHALL enter DRAIN for exactly PIPE_LAT cycles with rd_en=0.
REQ-020 At the end of DRAIN the FSM SHALL either return to RUN with s+1 and b=0, or, if s=7, enter DONE.
REQ-021 wr_en, wr_addr0 and wr_addr1 SHALL be rd_en, rd_addr0 and rd_addr1 delayed by exactly PIPE_LAT cycles through a shift register.
REQ-022 The drain SHALL guarantee that the last write of stage s precedes the first read of stage s+1.
REQ-023 Cycle timing relative to the start-sample cycle 0: the stage-s reads SHALL occur in cycles 1+130s .. 128+130s.
REQ-024 The final write SHALL occur in cycle 1040.
REQ-025 busy SHALL be 1 in cycles 1..1040.
REQ-026 done SHALL be 1 only in cycle 1041 (DONE state), after which the FSM SHALL return to IDLE.
REQ-027 Total latency SHALL be 1041 cycles from start to done.
REQ-028 Outside RUN, rd_addr0, rd_addr1 and zeta_addr SHALL hold 0.
REQ-029 wr_addr0 and wr_addr1 SHALL be 0 whenever wr_en=0.
REQ-030 All address arithmetic SHALL be unsigned ADDR_W bits, and no wrap beyond 255 SHALL occur.

Reset
REQ-031 When reset=0 at any time, including mid-transform, the block SHALL go immediately to IDLE and clear s, b and the delay line.
REQ-032 While reset=0, busy, done, rd_en, wr_en and all address outputs SHALL be 0.
REQ-033 After release, no stale wr_en SHALL appear.

Structure
REQ-034 Package ntt_pkg SHALL hold N=256, LOG_N=8, PIPE_LAT and the FSM state enum.
REQ-035 Sub-module ntt_addr_gen (combinational: s, b -> rd_addr0, rd_addr1, zeta_addr) SHALL be instantiated once.
REQ-036 The block SHALL contain no arithmetic datapath; the coefficient data SHALL flow from RAM to the butterfly to RAM externally.

Verification
REQ-037 First-cycle check: start pulse -> cycle 1 rd_en=1, rd_addr0=0, rd_addr1=128, zeta_addr=1; cycle 3 wr_en=1, wr_addr0=0, wr_addr1=128.
REQ-038 Mid-stage check: stage 1, b=64 (cycle 195) -> rd_addr0=128, rd_addr1=192, zeta_addr=3; stage 7, b=127 (cycle 1038) -> 254/255, zeta_addr=255.
REQ-039 Full-transform check: with RAM, zeta ROM and butterfly attached, a=[1,0,...,0] -> after done all 256 coefficients = 1; random input -> matches the golden ML-DSA NTT mod 8380417.
REQ-040 Timing check: start held high for 3 cycles -> exactly one transform; busy high 1040 cycles; done single pulse at 1041; 1024 rd_en and 1024 wr_en counted.
REQ-041 Reset-abort check: reset=0 at cycle 500 -> all outputs 0 immediately; after release, new start -> cycle 1 addresses 0/128/1 again and no stray wr_en.
REQ-042 Hazard check: assertion that no read address equals any write address pending in the delay line.
